// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and the blocks that drive it.
package regfile_pkg;

    localparam int unsigned RF_AW  = 5;
    localparam int unsigned RF_DW  = 16;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        SEL_IDLE  = 3'b000,
        SEL_WRITE = 3'b001,
        SEL_READ  = 3'b010
    } sel_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with a single-requester priority override.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    input  logic            i_ovr_en,
    input  logic [IW-1:0]   i_ovr_idx,
    output logic [NREQ-1:0] o_grant_c,
    output logic [IW-1:0]   o_idx_c
);

    logic          w_found;
    logic [IW-1:0] w_cand;

    // Override wins only while its requester is still asking; otherwise scan from ptr+1.
    always_comb begin
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        if (i_ovr_en && i_req[i_ovr_idx]) begin
            o_grant_c[i_ovr_idx] = 1'b1;
            o_idx_c              = i_ovr_idx;
        end else begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                w_cand = IW'((32'(i_ptr) + k) % NREQ);
                if (!w_found && i_req[w_cand]) begin
                    w_found           = 1'b1;
                    o_grant_c[w_cand] = 1'b1;
                    o_idx_c           = w_cand;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file between NREQ requesters: round-robin grant with
// bounded locking, registered regfile drive and a tagged read-response pipeline.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned AW       = RF_AW,
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          ReqValid,
    input  logic [NREQ-1:0]          ReqWrite,
    input  logic [NREQ-1:0]          ReqLock,
    input  logic [NREQ*AW-1:0]       ReqAddr,
    input  logic [NREQ*DW-1:0]       ReqData,
    output logic [NREQ-1:0]          ReqReady,
    output logic                     RespValid,
    output logic [$clog2(NREQ)-1:0]  RespId,
    output logic [DW-1:0]            RespData,
    output logic [AW-1:0]            ReadRegister1,
    output logic [AW-1:0]            WriteRegister,
    output logic [DW-1:0]            WriteData,
    output logic [SEL_W-1:0]         Sel,
    input  logic [DW-1:0]            ReadData1,
    output logic [AW-1:0]            ReadRegister2
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = 8;

    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_lock_cnt;
    logic            r_lock_vld;
    sel_e            r_sel;
    logic [AW-1:0]   r_rd_reg;
    logic [AW-1:0]   r_wr_reg;
    logic [DW-1:0]   r_wr_data;
    logic            r_resp_valid;
    logic [IW-1:0]   r_resp_id;
    logic [DW-1:0]   r_resp_data;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_gidx;
    logic            w_xfer;
    logic            w_ovr_en;
    logic            w_lock_hit;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;

    // Lock holds priority only for the arbitration right after a locked grant, up to LOCK_MAX in a row.
    assign w_ovr_en = r_lock_vld && (r_lock_cnt < CW'(LOCK_MAX));

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .i_req     (ReqValid),
        .i_ptr     (r_ptr),
        .i_ovr_en  (w_ovr_en),
        .i_ovr_idx (r_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_gidx)
    );

    assign w_xfer     = |w_grant;
    assign w_lock_hit = w_xfer && w_ovr_en && (w_gidx == r_ptr);
    assign w_addr     = ReqAddr[32'(w_gidx)*AW +: AW];
    assign w_data     = ReqData[32'(w_gidx)*DW +: DW];

    // Ptr and lock bookkeeping plus the registered regfile drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= IW'(NREQ - 1);
            r_lock_cnt <= '0;
            r_lock_vld <= 1'b0;
            r_sel      <= SEL_IDLE;
            r_rd_reg   <= '0;
            r_wr_reg   <= '0;
            r_wr_data  <= '0;
        end else if (w_xfer) begin
            r_ptr      <= w_gidx;
            r_lock_vld <= ReqLock[w_gidx];
            r_lock_cnt <= w_lock_hit ? (r_lock_cnt + CW'(1)) :
                          (ReqLock[w_gidx] ? CW'(1) : CW'(0));
            r_sel      <= ReqWrite[w_gidx] ? SEL_WRITE : SEL_READ;
            r_rd_reg   <= w_addr;
            r_wr_reg   <= w_addr;
            r_wr_data  <= w_data;
        end else begin
            r_lock_vld <= 1'b0;
            r_lock_cnt <= '0;
            r_sel      <= SEL_IDLE;
        end
    end

    // Read response: Ptr still names the requester during its SEL_READ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= (r_sel == SEL_READ);
            if (r_sel == SEL_READ) begin
                r_resp_id   <= r_ptr;
                r_resp_data <= ReadData1;
            end
        end
    end

    assign ReqReady      = w_grant & {NREQ{rst_n}};
    assign RespValid     = r_resp_valid;
    assign RespId        = r_resp_id;
    assign RespData      = r_resp_data;
    assign ReadRegister1 = r_rd_reg;
    assign WriteRegister = r_wr_reg;
    assign WriteData     = r_wr_data;
    assign Sel           = r_sel;
    assign ReadRegister2 = '0;

endmodule
